// File: rtl/win_pkg.sv
// Shared constants and state encoding for the 3x3 window feeder.
package win_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/line_buf.sv
// Shift-register line buffer: dout is the sample written DEPTH shifts ago.
module line_buf
  import win_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_IMG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Shift one slot per captured pixel; reset wipes the whole row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/window_feeder.sv
// Streams a frame out of a pixel FIFO and presents sliding 3x3 windows to
// the convolution core. Optional feature macro: WIN_CNT_EN adds the
// saturating win_count output.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | issuing reads and capturing pixels of the frame
// DONE  | one-cycle frame_done pulse, then back to IDLE
module window_feeder
  import win_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_dout,
  output logic               fifo_ren,
  output logic               win_update,
  output logic [3*WIDTH-1:0] activate2,
  output logic [3*WIDTH-1:0] activate1,
  output logic [3*WIDTH-1:0] activate0,
  output logic               busy,
  output logic               frame_done
`ifdef WIN_CNT_EN
  ,
  output logic [15:0]        win_count
`endif
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [CNT_W-1:0] NPIX_C   = CNT_W'(NPIX);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_left;
  logic             pix_vld;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [WIDTH-1:0] lb1_dout, lb2_dout;
  logic [WIDTH-1:0] win_q   [3][3];
  logic [WIDTH-1:0] win_nxt [3][3];
  logic             start_ok;
  logic             last_pix;
  logic             win_hit;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign last_pix = pix_vld && (col_q == COL_LAST) && (row_q == ROW_LAST);
  // Only windows whose three columns all lie in the current row are valid
  assign win_hit  = pix_vld && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    fifo_ren   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy     = 1'b1;
        fifo_ren = !fifo_empty && (rd_left != '0);
        if (last_pix) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads still to issue this frame; stops reads once the frame is requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rd_left <= '0;
    else if (start_ok) rd_left <= NPIX_C;
    else if (fifo_ren) rd_left <= rd_left - 1'b1;
  end

  // FIFO data lands one cycle after the read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_vld <= 1'b0;
    else     pix_vld <= fifo_ren;
  end

  // Position of the pixel being captured next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (start_ok) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_vld) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (pix_vld),
    .din      (fifo_dout),
    .dout     (lb1_dout)
  );

  line_buf #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_lb2 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (pix_vld),
    .din      (lb1_dout),
    .dout     (lb2_dout)
  );

  // Window after this capture: drop column c-2, append the new column
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      win_nxt[k][0] = win_q[k][1];
      win_nxt[k][1] = win_q[k][2];
    end
    win_nxt[0][2] = lb2_dout;
    win_nxt[1][2] = lb1_dout;
    win_nxt[2][2] = fifo_dout;
  end

  // Sliding 3x3 window register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++) win_q[k][j] <= '0;
    end else if (start_ok) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++) win_q[k][j] <= '0;
    end else if (pix_vld) begin
      win_q <= win_nxt;
    end
  end

  // Presented window only changes with a strobe, so the core sees it stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_update <= 1'b0;
      activate2  <= '0;
      activate1  <= '0;
      activate0  <= '0;
    end else begin
      win_update <= win_hit;
      if (win_hit) begin
        activate2 <= {win_nxt[0][0], win_nxt[0][1], win_nxt[0][2]};
        activate1 <= {win_nxt[1][0], win_nxt[1][1], win_nxt[1][2]};
        activate0 <= {win_nxt[2][0], win_nxt[2][1], win_nxt[2][2]};
      end
    end
  end

`ifdef WIN_CNT_EN
  // Windows emitted since start; saturates rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     win_count <= '0;
    else if (start_ok)                           win_count <= '0;
    else if (win_update && win_count != 16'hFFFF) win_count <= win_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_window_feeder.sv
// Bench for window_feeder on a 4x4 frame; build with WIN_CNT_EN to also
// exercise win_count.
module tb_window_feeder;

  localparam int WD = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [WD-1:0]   fifo_dout = '0;
  logic            fifo_ren;
  logic            win_update;
  logic [3*WD-1:0] activate2, activate1, activate0;
  logic            busy, frame_done;
`ifdef WIN_CNT_EN
  logic [15:0]     win_count;
  logic [15:0]     cnt_after_start;
`endif

  window_feeder #(.WIDTH(WD), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .win_update (win_update),
    .activate2  (activate2),
    .activate1  (activate1),
    .activate0  (activate0),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef WIN_CNT_EN
    ,
    .win_count  (win_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [WD-1:0]   pix_q [$];
  logic [WD-1:0]   img   [NP];
  logic [3*WD-1:0] got2 [$];
  logic [3*WD-1:0] got1 [$];
  logic [3*WD-1:0] got0 [$];
  int reads, viol, fd_cnt, fd_cyc, last_win_cyc, cyc, gap_mode;
  logic gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a window row is three consecutive pixels of one image row
  function automatic logic [3*WD-1:0] exp_row(input int r, input int c);
    return {img[r*W + c - 2], img[r*W + c - 1], img[r*W + c]};
  endfunction

  task automatic clear_stats();
    got2.delete(); got1.delete(); got0.delete();
    reads = 0; viol = 0; fd_cnt = 0; fd_cyc = -1; last_win_cyc = -1;
  endtask

  // One clock: observe at negedge, then act as the FIFO after the edge
  task automatic tick();
    logic ren;
    @(negedge clk);
    ren = fifo_ren;
    if (ren && fifo_empty) viol++;
    if (ren) reads++;
    if (win_update) begin
      got2.push_back(activate2);
      got1.push_back(activate1);
      got0.push_back(activate0);
      last_win_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ren && pix_q.size() > 0) fifo_dout = pix_q.pop_front();
    case (gap_mode)
      1:       gap = ~gap;
      2:       gap = ($urandom_range(0, 2) == 0);
      default: gap = 1'b0;
    endcase
    fifo_empty = (pix_q.size() == 0) || gap;
  endtask

  task automatic load_pixels(input int n, input bit ramp);
    pix_q.delete();
    for (int i = 0; i < n; i++) pix_q.push_back(ramp ? WD'(i) : WD'($urandom));
    for (int i = 0; i < NP; i++) img[i] = pix_q[i];
  endtask

  task automatic run_frame(input int abort_reads, input int restart_at);
    clear_stats();
    gap = 1'b0;
    fifo_empty = (pix_q.size() == 0);
    for (int n = 0; n < 2000; n++) begin
      start = (n == 0) || (n == restart_at);
      tick();
`ifdef WIN_CNT_EN
      if (n == 0) cnt_after_start = win_count;
`endif
      if (abort_reads > 0 && reads >= abort_reads) break;
      if (fd_cnt > 0 && cyc > fd_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic verify_frame(input string name);
    check({name, "_win_cnt"}, got0.size(), NWIN);
    for (int i = 0; i < got0.size() && i < NWIN; i++) begin
      int r, c;
      r = 2 + i / (W - 2);
      c = 2 + i % (W - 2);
      check($sformatf("%s_w%0d_a2", name, i), got2[i], exp_row(r - 2, c));
      check($sformatf("%s_w%0d_a1", name, i), got1[i], exp_row(r - 1, c));
      check($sformatf("%s_w%0d_a0", name, i), got0[i], exp_row(r, c));
    end
    check({name, "_frame_done_once"}, fd_cnt, 1);
    check({name, "_done_after_last_win"}, 32'(fd_cyc >= last_win_cyc), 1);
    check({name, "_ren_while_empty"}, viol, 0);
    check({name, "_reads"}, reads, NP);
    check({name, "_busy_idle"}, busy, 0);
`ifdef WIN_CNT_EN
    check({name, "_cnt_after_start"}, cnt_after_start, 0);
    check({name, "_win_count"}, win_count, NWIN);
`endif
  endtask

  task automatic check_quiet(input string name);
    check({name, "_ren"}, fifo_ren, 0);
    check({name, "_upd"}, win_update, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, frame_done, 0);
    check({name, "_a2"}, activate2, 0);
    check({name, "_a1"}, activate1, 0);
    check({name, "_a0"}, activate0, 0);
  endtask

  initial begin
    cyc = 0;
    gap_mode = 0;
    gap = 1'b0;
    clear_stats();
    #1;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) tick();
    check_quiet("idle");

    // Ramp frame, FIFO always ready
    load_pixels(NP, 1'b1);
    run_frame(0, -1);
    verify_frame("ramp");
    if (got0.size() == NWIN) begin
      check("ramp_first_a2", got2[0], 24'h000102);
      check("ramp_first_a1", got1[0], 24'h040506);
      check("ramp_first_a0", got0[0], 24'h08090A);
      check("ramp_last_a0", got0[NWIN-1], 24'h0D0E0F);
    end else begin
      check("ramp_window_total", got0.size(), NWIN);
    end

    // Same frame, FIFO empty every other cycle
    gap_mode = 1;
    load_pixels(NP, 1'b1);
    run_frame(0, -1);
    verify_frame("alt_empty");
    gap_mode = 0;

    // Reset mid-frame, then a clean frame
    load_pixels(NP, 1'b1);
    run_frame(10, -1);
    check("abort_no_done", fd_cnt, 0);
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    pix_q.delete();
    fifo_empty = 1'b1;
    clear_stats();
    repeat (6) tick();
    check("midrst_no_win", got0.size(), 0);
    check("midrst_no_done", fd_cnt, 0);
    load_pixels(NP, 1'b0);
    run_frame(0, -1);
    verify_frame("post_rst");

    // Start re-pulsed mid-frame must be ignored
    load_pixels(NP, 1'b0);
    run_frame(0, 8);
    verify_frame("restart");

    // FIFO holds more than a frame
    load_pixels(NP + 4, 1'b0);
    run_frame(0, -1);
    verify_frame("surplus");
    check("surplus_left", pix_q.size(), 4);

    // Random pixels with random FIFO stalls
    gap_mode = 2;
    for (int f = 0; f < 3; f++) begin
      load_pixels(NP, 1'b0);
      run_frame(0, -1);
      verify_frame($sformatf("rand%0d", f));
    end
    gap_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/window_feeder.md
WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 28: pixels per image row, minimum 3.
REQ-003 SHALL have parameter IMG_H, default 28: rows per frame, minimum 3.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge; one clock in the block.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame.
- fifo_empty  in  1  pixel FIFO empty flag.
- fifo_dout  in  WIDTH  FIFO read data, valid the cycle after fifo_ren.
- fifo_ren  out  1  FIFO read strobe.
- win_update  out  1  window-valid strobe to the convolution core's in_update.
- activate2  out  3*WIDTH  window row r-2.
- activate1  out  3*WIDTH  window row r-1.
- activate0  out  3*WIDTH  window row r (newest).
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last window.

Function
REQ-005 SHALL implement states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE on the cycle the IMG_W*IMG_H-th pixel is captured; DONE->IDLE unconditionally after one cycle.
REQ-006 SHALL ignore start outside IDLE.
REQ-007 SHALL drive fifo_ren = (state==RUN) & ~fifo_empty & (reads issued < IMG_W*IMG_H), combinationally.
REQ-008 SHALL register pix_vld = fifo_ren delayed one cycle and capture fifo_dout only when pix_vld=1; with fifo_empty=1, no pixel or column advances.
REQ-009 SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters for the captured pixel: col wraps to 0 and row increments after IMG_W-1; both clear on start.
REQ-010 SHALL keep two line buffers of IMG_W entries each, holding rows r-1 and r-2, shifted only on pix_vld.
REQ-011 SHALL shift a 3x3 window register on pix_vld, loading the new column {line r-2, line r-1, fifo_dout}.
REQ-012 SHALL pack each activateN with [3W-1:2W]=column c-2, [2W-1:W]=column c-1, [W-1:0]=column c.
REQ-013 SHALL assert win_update for one cycle, the cycle after capture, when the captured pixel has row>=2 and col>=2, with activate* holding that window in the same cycle.
REQ-014 SHALL produce exactly (IMG_W-2)*(IMG_H-2) win_update pulses per frame; windows spanning a row wrap SHALL NOT be flagged.
REQ-015 SHALL hold activate* stable while win_update=0.
REQ-016 SHALL assert frame_done in DONE, coincident with or after the final win_update, and hold busy=1 in RUN and DONE.

Reset
REQ-017 SHALL, on rst=1 at any time including mid-frame, asynchronously force state=IDLE and clear counters, pix_vld, window registers, and line buffers; fifo_ren, win_update, busy, frame_done, and activate* SHALL read 0.
REQ-018 SHALL NOT emit win_update or frame_done for a frame interrupted by reset.

Configuration
REQ-019 SHALL, when WIN_CNT_EN is defined, add output win_count (16 bits), cleared on start and reset, incremented on each win_update, saturating at 16'hFFFF; without WIN_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-020 SHALL take state encodings and the default WIDTH/IMG_W/IMG_H constants from shared package win_pkg.
REQ-021 SHALL instantiate sub-module line_buf (parameters WIDTH, DEPTH; ports clk, rst, shift_en, din, dout) twice.

Verification
REQ-022 SHALL check that IMG_W=4, IMG_H=4, pixels 0..15, FIFO never empty -> 4 win_update pulses; the first has activate2={0,1,2}, activate1={4,5,6}, activate0={8,9,10}; the last has activate0={13,14,15}; frame_done follows.
REQ-023 SHALL check that the same frame with fifo_empty=1 on every other cycle -> identical window contents and count, and fifo_ren is never high while empty.
REQ-024 SHALL check that rst pulsed after pixel 9 -> all outputs 0 immediately; a new start and 16 pixels -> a correct 4-window frame with no stale data.
REQ-025 SHALL check that start re-pulsed during RUN -> ignored, and counters and windows are unaffected.
REQ-026 SHALL check that FIFO holding 20 pixels for a 16-pixel frame -> exactly 16 reads, and 4 pixels remain.
REQ-027 SHALL check that with WIN_CNT_EN, win_count=4 after the frame and 0 after the next start.
